// File: rtl/wavelet_stream_sequencer.sv
// Frame sequencer for a baseline-removal datapath: forwards a fixed number of
// beats, counts returned beats, measures first-in to first-out latency.
module wavelet_stream_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 16,
  parameter int EXP_LAT    = 155,
  parameter int TIMEOUT    = 308,
  parameter int LEN_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [LEN_W-1:0]            frame_len,
  input  logic                        src_valid,
  input  logic [DATA_WIDTH*LANES-1:0] src_data,
  output logic                        src_ready,
  output logic                        dut_din_valid,
  output logic [DATA_WIDTH*LANES-1:0] dut_din,
  input  logic                        dut_baseline_valid,
  output logic                        busy,
  output logic                        done,
  output logic [LEN_W-1:0]            out_cnt,
  output logic [15:0]                 latency_meas,
  output logic                        latency_err,
  output logic                        timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                        state_q, state_d;
  logic [LEN_W-1:0]              len_q;
  logic [LEN_W-1:0]              in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0]              out_cnt_q, out_cnt_d;
  logic [TO_W-1:0]               idle_q, idle_d;
  logic [15:0]                   lat_cnt_q;
  logic                          lat_run_q;
  logic                          lat_seen_q;
  logic [15:0]                   lat_meas_q;
  logic                          lat_err_q;
  logic                          tout_err_q;
  logic                          src_ready_q;
  logic                          din_valid_q;
  logic [DATA_WIDTH*LANES-1:0]   din_q;
  logic                          busy_q;
  logic                          done_q;

  logic hs;
  logic fwd;
  logic bv_live;
  logic start_ok;
  logic tout_hit;

  assign src_ready     = src_ready_q;
  assign dut_din_valid = din_valid_q;
  assign dut_din       = din_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign out_cnt       = out_cnt_q;
  assign latency_meas  = lat_meas_q;
  assign latency_err   = lat_err_q;
  assign timeout_err   = tout_err_q;

  always_comb begin
    hs       = src_ready_q & src_valid;
    // A handshake in the abort cycle is dropped so nothing leaks downstream.
    fwd      = hs & ~abort;
    bv_live  = dut_baseline_valid & ((state_q == S_RUN) | (state_q == S_FLUSH));
    start_ok = (state_q == S_IDLE) & start & ~abort & (frame_len != '0);
    in_cnt_d  = hs ? in_cnt_q + LEN_W'(1) : in_cnt_q;
    out_cnt_d = (bv_live && (out_cnt_q < len_q)) ? out_cnt_q + LEN_W'(1) : out_cnt_q;
    idle_d    = ((state_q == S_FLUSH) && !dut_baseline_valid) ? idle_q + TO_W'(1) : '0;
    tout_hit  = 1'b0;
    state_d   = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_RUN;
      S_RUN: begin
        if (abort)                           state_d = S_IDLE;
        else if (hs && (in_cnt_d == len_q))  state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (abort)                      state_d = S_IDLE;
        else if (out_cnt_d == len_q)    state_d = S_DONE;
        else if (!dut_baseline_valid && (idle_q == TO_W'(TIMEOUT - 1))) begin
          state_d  = S_DONE;
          tout_hit = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      idle_q      <= '0;
      lat_cnt_q   <= '0;
      lat_run_q   <= 1'b0;
      lat_seen_q  <= 1'b0;
      lat_meas_q  <= '0;
      lat_err_q   <= 1'b0;
      tout_err_q  <= 1'b0;
      src_ready_q <= 1'b0;
      din_valid_q <= 1'b0;
      din_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      idle_q      <= idle_d;
      din_valid_q <= fwd;
      if (fwd) din_q <= src_data;

      if (start_ok) begin
        len_q       <= frame_len;
        in_cnt_q    <= '0;
        out_cnt_q   <= '0;
        lat_cnt_q   <= '0;
        lat_run_q   <= 1'b0;
        lat_seen_q  <= 1'b0;
        lat_meas_q  <= '0;
        lat_err_q   <= 1'b0;
        tout_err_q  <= 1'b0;
        src_ready_q <= 1'b1;
      end else begin
        in_cnt_q    <= in_cnt_d;
        out_cnt_q   <= out_cnt_d;
        src_ready_q <= (state_d == S_RUN) && (in_cnt_d < len_q);
        if (tout_hit) tout_err_q <= 1'b1;
        // Counter reads 0 in the cycle the first beat appears downstream.
        if (fwd && !lat_run_q) begin
          lat_run_q <= 1'b1;
          lat_cnt_q <= '0;
        end else if (lat_run_q && (lat_cnt_q != '1)) begin
          lat_cnt_q <= lat_cnt_q + 16'd1;
        end
        if (bv_live && !lat_seen_q) begin
          lat_seen_q <= 1'b1;
          lat_meas_q <= lat_cnt_q;
          lat_err_q  <= (lat_cnt_q != 16'(EXP_LAT));
        end
      end
    end
  end

endmodule

// File: tb/tb_wavelet_stream_sequencer.sv
// Scoreboard bench for wavelet_stream_sequencer with a delay-line datapath model.
module tb_wavelet_stream_sequencer;

  localparam int DW = 16;
  localparam int L  = 16;
  localparam int W  = DW * L;

  typedef struct {
    logic [15:0] ocnt;
    logic [15:0] lat;
    logic        lerr;
    logic        terr;
  } done_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   frame_len = '0;
  logic          src_valid = 1'b0;
  logic [W-1:0]  src_data = '0;
  logic          src_ready;
  logic          dut_din_valid;
  logic [W-1:0]  dut_din;
  logic          dut_baseline_valid = 1'b0;
  logic          busy;
  logic          done;
  logic [15:0]   out_cnt;
  logic [15:0]   latency_meas;
  logic          latency_err;
  logic          timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_din[$];
  done_t        exp_done[$];

  int  cyc = 0;
  int  din_pulses = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  last_bv_cyc = 0;
  bit  pend = 1'b0;

  int  mdl_dly = 155;
  int  mdl_max = 1000;
  int  mdl_emit = 0;
  bit  sr [0:511];

  wavelet_stream_sequencer #(
    .DATA_WIDTH(DW),
    .LANES(L),
    .EXP_LAT(155),
    .TIMEOUT(308),
    .LEN_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .abort(abort),
    .frame_len(frame_len),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .dut_din_valid(dut_din_valid),
    .dut_din(dut_din),
    .dut_baseline_valid(dut_baseline_valid),
    .busy(busy),
    .done(done),
    .out_cnt(out_cnt),
    .latency_meas(latency_meas),
    .latency_err(latency_err),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Datapath model: returns one baseline strobe mdl_dly cycles after each input beat.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) sr[i] = 1'b0;
      dut_baseline_valid = 1'b0;
    end else begin
      for (int i = 511; i > 0; i--) sr[i] = sr[i-1];
      sr[0] = dut_din_valid;
      if (sr[mdl_dly] && (mdl_emit < mdl_max)) begin
        dut_baseline_valid = 1'b1;
        mdl_emit++;
        last_bv_cyc = cyc;
      end else begin
        dut_baseline_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expected beats / frame results whenever the DUT presents them.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
    end else begin
      if (dut_din_valid || pend) chk("din_valid_timing", W'(dut_din_valid), W'(pend));
      if (dut_din_valid) begin
        din_pulses++;
        if (exp_din.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL din_unexpected: got beat %0h expected none", dut_din);
        end else begin
          chk("din_data", dut_din, exp_din.pop_front());
        end
      end
      if (done) begin
        done_t e;
        done_cnt++;
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL done_unexpected: got done=1 expected 0");
        end else begin
          e = exp_done.pop_front();
          chk("done_out_cnt", W'(out_cnt), W'(e.ocnt));
          chk("done_latency_meas", W'(latency_meas), W'(e.lat));
          chk("done_latency_err", W'(latency_err), W'(e.lerr));
          chk("done_timeout_err", W'(timeout_err), W'(e.terr));
        end
      end
      pend = src_valid & src_ready & ~abort;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int k = 0; k < W / 32; k++) src_data[k*32 +: 32] = $urandom;
  endtask

  task automatic run_frame(input int len, input int dly, input int maxo, input bit toggle,
                           input int rlen, input logic [15:0] elat, input bit eerr,
                           input int eout, input bit etout);
    done_t e;
    int hs_n, i, d0, n;
    e.ocnt = 16'(eout); e.lat = elat; e.lerr = eerr; e.terr = etout;
    exp_done.push_back(e);
    mdl_dly = dly; mdl_max = maxo; mdl_emit = 0;
    din_pulses = 0;
    d0 = done_cnt;
    start = 1'b1; frame_len = 16'(len); src_valid = 1'b0;
    next_cycle();
    start = 1'b0;
    hs_n = 0; i = 0;
    while (hs_n < len && i < 200) begin
      start = (rlen != 0) && (i == 0);
      if (start) frame_len = 16'(rlen);
      src_valid = toggle ? (i % 2 == 0) : 1'b1;
      rand_data();
      if (src_valid && src_ready && !abort) begin
        exp_din.push_back(src_data);
        hs_n++;
      end
      i++;
      next_cycle();
    end
    start = 1'b0;
    src_valid = 1'b0;
    chk("handshakes_done", W'(hs_n), W'(len));
    chk("src_ready_after_last", W'(src_ready), W'(0));
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      next_cycle();
      n++;
    end
    if (done_cnt == d0) begin
      n_assert++; n_fail++;
      $display("FAIL done_wait: got no done within 2000 cycles, expected one");
    end
    chk("din_pulse_count", W'(din_pulses), W'(len));
    repeat (4) next_cycle();
    chk("idle_busy", W'(busy), W'(0));
    chk("hold_out_cnt", W'(out_cnt), W'(eout));
    chk("hold_latency_meas", W'(latency_meas), W'(elat));
    chk("single_done", W'(done_cnt - d0), W'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_n, d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_src_ready", W'(src_ready), W'(0));
    chk("rst_din_valid", W'(dut_din_valid), W'(0));
    chk("rst_din", dut_din, '0);
    chk("rst_out_cnt", W'(out_cnt), W'(0));
    chk("rst_latency", W'({latency_meas, latency_err, timeout_err}), W'(0));
    rst_n = 1'b1;
    repeat (2) next_cycle();

    // Nominal frame, matched latency.
    run_frame(4, 155, 1000, 1'b0, 0, 16'd155, 1'b0, 4, 1'b0);
    repeat (170) next_cycle();
    // Short datapath delay.
    run_frame(4, 150, 1000, 1'b0, 0, 16'd150, 1'b1, 4, 1'b0);
    repeat (170) next_cycle();
    // Datapath drops the last output: FLUSH times out.
    run_frame(3, 155, 2, 1'b0, 0, 16'd155, 1'b0, 2, 1'b1);
    chk("timeout_gap", W'(done_cyc - last_bv_cyc), W'(309));
    repeat (170) next_cycle();
    // Bursty source.
    run_frame(5, 155, 1000, 1'b1, 0, 16'd155, 1'b0, 5, 1'b0);
    repeat (170) next_cycle();

    // start with abort in IDLE.
    start = 1'b1; abort = 1'b1; frame_len = 16'd4;
    next_cycle();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", W'(busy), W'(0));
    chk("start_abort_ready", W'(src_ready), W'(0));
    next_cycle();
    chk("start_abort_busy2", W'(busy), W'(0));

    // Abort mid-frame after two beats.
    mdl_dly = 155; mdl_max = 1000; mdl_emit = 0;
    d0 = done_cnt;
    start = 1'b1; frame_len = 16'd6;
    next_cycle();
    start = 1'b0;
    hs_n = 0;
    for (int i = 0; i < 20 && hs_n < 2; i++) begin
      src_valid = 1'b1;
      rand_data();
      if (src_ready) begin
        exp_din.push_back(src_data);
        hs_n++;
      end
      next_cycle();
    end
    chk("abort_pre_ready", W'(src_ready), W'(1));
    abort = 1'b1;
    rand_data();
    next_cycle();
    abort = 1'b0; src_valid = 1'b0;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_src_ready", W'(src_ready), W'(0));
    chk("abort_din_valid", W'(dut_din_valid), W'(0));
    repeat (200) next_cycle();
    chk("abort_no_done", W'(done_cnt - d0), W'(0));

    // Zero-length start is ignored.
    start = 1'b1; frame_len = 16'd0;
    next_cycle();
    start = 1'b0;
    chk("zero_len_busy", W'(busy), W'(0));
    chk("zero_len_ready", W'(src_ready), W'(0));

    // Restart while busy is ignored; the original length stands.
    run_frame(2, 155, 1000, 1'b0, 7, 16'd155, 1'b0, 2, 1'b0);

    chk("din_queue_empty", W'(exp_din.size()), W'(0));
    chk("done_queue_empty", W'(exp_done.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wavelet_stream_sequencer.md
WAVELET_STREAM_SEQUENCER -- requirements
Module: wavelet_stream_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16: sample width per lane.
REQ-002 The block SHALL have parameter LANES, default 16: samples per beat.
REQ-003 The block SHALL have parameter EXP_LAT, default 155: expected first-in to first-out latency of the baseline-removal datapath, in cycles.
REQ-004 The block SHALL have parameter TIMEOUT, default 308: maximum idle cycles allowed in FLUSH.
REQ-005 The block SHALL have parameter LEN_W, default 16: width of the frame-length field.
REQ-006 The block SHALL have one clock and an asynchronous active-low reset: clk, input, 1, the only clock.
REQ-007 rst_n, input, 1: asynchronous active-low reset.
REQ-008 start, input, 1: single-cycle frame-start request.
REQ-009 abort, input, 1: synchronous frame cancel.
REQ-010 frame_len, input, LEN_W: beats per frame, sampled at start.
REQ-011 src_valid, input, 1: upstream beat valid.
REQ-012 src_data, input, DATA_WIDTH*LANES: upstream beat, lane i at bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
REQ-013 src_ready, output, 1: sequencer accepts a beat.
REQ-014 dut_din_valid, output, 1: valid strobe to the datapath.
REQ-015 dut_din, output, DATA_WIDTH*LANES: beat to the datapath.
REQ-016 dut_baseline_valid, input, 1: output-valid strobe from the datapath.
REQ-017 busy, output, 1: high in any state other than IDLE.
REQ-018 done, output, 1: one-cycle pulse at frame end.
REQ-019 out_cnt, output, LEN_W: count of output beats in the current frame.
REQ-020 latency_meas, output, 16: measured datapath latency.
REQ-021 latency_err, output, 1: latency_meas differed from EXP_LAT.
REQ-022 timeout_err, output, 1: FLUSH ended by timeout.

Function
REQ-023 The FSM SHALL have exactly four states: IDLE, RUN, FLUSH, DONE; all outputs SHALL be registered.
REQ-024 In IDLE, start=1 with frame_len!=0 and abort=0 SHALL latch frame_len, clear in_cnt, out_cnt, latency_meas, latency_err and timeout_err, and enter RUN the next cycle.
REQ-025 In IDLE, start with frame_len=0 SHALL be ignored; start in any state other than IDLE SHALL be ignored.
REQ-026 src_ready SHALL be 1 only in RUN, and only while in_cnt < the latched length.
REQ-027 A handshake (src_valid & src_ready) SHALL produce dut_din_valid=1 and dut_din=src_data exactly one cycle later; in every other cycle dut_din_valid SHALL be 0 and dut_din SHALL hold its last value.
REQ-028 Each handshake SHALL increment in_cnt; the handshake that brings in_cnt to the latched length SHALL move RUN to FLUSH the next cycle.
REQ-029 In RUN and FLUSH, each dut_baseline_valid SHALL increment out_cnt, saturating at the latched length; in IDLE and DONE, dut_baseline_valid SHALL be ignored.
REQ-030 The latency counter SHALL start at 0 in the cycle of the first dut_din_valid of the frame and increment each cycle thereafter.
REQ-031 On the first dut_baseline_valid of the frame, latency_meas SHALL latch the counter value and latency_err SHALL be set if that value != EXP_LAT.
REQ-032 If dut_baseline_valid occurs in the same cycle as the first dut_din_valid, latency_meas SHALL latch 0.
REQ-033 The latency counter SHALL saturate at 16'hFFFF.
REQ-034 FLUSH SHALL go to DONE when out_cnt reaches the latched length, including the increment made in the current cycle.
REQ-035 FLUSH SHALL also go to DONE, setting timeout_err, after TIMEOUT consecutive cycles without dut_baseline_valid.
REQ-036 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-037 latency_meas, latency_err, timeout_err and out_cnt SHALL hold until the next accepted start.
REQ-038 abort=1 in RUN or FLUSH SHALL return the FSM to IDLE the next cycle with no done pulse; src_ready and any pending dut_din_valid SHALL be 0 from that cycle.
REQ-039 abort SHALL take priority over start and over every other transition in the same cycle.

Reset
REQ-040 While rst_n=0, the FSM SHALL be in IDLE and all outputs and counters SHALL be 0, including dut_din.
REQ-041 Reset mid-frame SHALL discard the frame with no done pulse.

Verification
REQ-042 Reset, then start with frame_len=4, src_valid held high, datapath model with 155-cycle delay -> 4 dut_din_valid pulses, out_cnt=4, done pulse once, latency_meas=155, latency_err=0.
REQ-043 Same as REQ-042 with the datapath delay set to 150 -> latency_meas=150, latency_err=1, done still pulses.
REQ-044 frame_len=3, datapath returns only 2 outputs -> done after 308 idle FLUSH cycles, timeout_err=1, out_cnt=2.
REQ-045 src_valid toggled every other cycle, frame_len=5 -> exactly 5 dut_din_valid pulses, each one cycle after its handshake, with data bit-exact; src_ready=0 after the 5th handshake.
REQ-046 start and abort together in IDLE -> remains IDLE, busy=0; abort during RUN after 2 beats -> IDLE next cycle, no done, dut_din_valid=0.
REQ-047 start with frame_len=0 -> ignored, busy=0; start while busy -> ignored, latched length unchanged.
